// File: rtl/session_pkg.sv
// Shared types and helpers for the grant-driven session controller.
package session_pkg;

  localparam int NUM_MASTERS = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE,
    SETTLE
  } sess_state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [NUM_MASTERS-1:0] v);
    return (v != '0) && ((v & (v - NUM_MASTERS'(1))) == '0);
  endfunction

endpackage

// File: rtl/granted_session_controller.sv
// Latches the arbiter's one-hot grant and forwards the owner's burst of m_len+1
// beats to the shared slave port, then pulses session_is_finished.
module granted_session_controller
  import session_pkg::*;
#(
  parameter int DW   = 32,
  parameter int LENW = 4
) (
  input  logic                                clk,
  input  logic                                rst_a,
  input  logic [NUM_MASTERS-1:0]              grant,
  output logic                                session_is_finished,
  input  logic [NUM_MASTERS-1:0][LENW-1:0]    m_len,
  input  logic [NUM_MASTERS-1:0]              m_valid,
  input  logic [NUM_MASTERS-1:0][DW-1:0]      m_data,
  output logic [NUM_MASTERS-1:0]              m_ready,
  output logic                                s_valid,
  output logic [DW-1:0]                       s_data,
  output logic                                s_last,
  output logic [1:0]                          s_id,
  input  logic                                s_ready,
  output logic                                busy,
  output logic                                protocol_err
);

  sess_state_t            state_q, state_d;
  logic [1:0]             id_q, id_d;
  logic [LENW-1:0]        len_q, len_d;
  logic [LENW-1:0]        cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   fin_q, fin_d;
  logic                   busy_q, busy_d;

  logic                   active;
  logic                   beat_acc;
  logic                   last_beat;
  logic [NUM_MASTERS-1:0] owner_oh;
  logic [1:0]             grant_idx;

  assign active    = (state_q == ACTIVE);
  assign owner_oh  = NUM_MASTERS'(1) << id_q;
  assign grant_idx = onehot_to_idx(grant);
  assign last_beat = (cnt_q == len_q);

  // Forwarding path is combinational so a beat can move in the first ACTIVE cycle.
  assign s_valid   = active & m_valid[id_q];
  assign s_data    = m_data[id_q];
  assign s_last    = active & last_beat;
  assign s_id      = id_q;
  assign m_ready   = (active & s_ready) ? owner_oh : '0;
  assign beat_acc  = s_valid & s_ready;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (is_onehot(grant)) begin
          id_d    = grant_idx;
          len_d   = m_len[grant_idx];
          cnt_d   = '0;
          state_d = ACTIVE;
        end else if (grant != '0) begin
          err_d = 1'b1;
        end
      end
      ACTIVE: begin
        // A moved or dropped grant is flagged but the session finishes on the latched owner.
        if (grant != owner_oh) err_d = 1'b1;
        if (beat_acc) begin
          if (last_beat) state_d = DONE;
          else           cnt_d   = cnt_q + LENW'(1);
        end
      end
      DONE:    state_d = SETTLE;
      // Arbiter grant is stale for one cycle after the pulse; ignore it here.
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    fin_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
    end
  end

  assign session_is_finished = fin_q;
  assign busy                = busy_q;
  assign protocol_err        = err_q;

endmodule

// File: tb/tb_granted_session_controller.sv
// Session table plus beat scoreboard for granted_session_controller.
module tb_granted_session_controller;

  localparam int DW   = 32;
  localparam int LENW = 4;

  logic                  clk = 1'b0;
  logic                  rst_a;
  logic [3:0]            grant;
  logic                  session_is_finished;
  logic [3:0][LENW-1:0]  m_len;
  logic [3:0]            m_valid;
  logic [3:0][DW-1:0]    m_data;
  logic [3:0]            m_ready;
  logic                  s_valid;
  logic [DW-1:0]         s_data;
  logic                  s_last;
  logic [1:0]            s_id;
  logic                  s_ready;
  logic                  busy;
  logic                  protocol_err;

  granted_session_controller #(.DW(DW), .LENW(LENW)) dut (
    .clk(clk), .rst_a(rst_a), .grant(grant), .session_is_finished(session_is_finished),
    .m_len(m_len), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_id(s_id),
    .s_ready(s_ready), .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    id;
    logic          last;
  } beat_t;

  typedef struct {
    logic [3:0]  grant;
    logic [3:0]  len;
    logic [15:0] rdy;
    logic        exp_err;
    int          exp_cyc;
    int          drop_at;
    int          chg_at;
  } vec_t;

  beat_t      sb[$];
  vec_t       tbl[12];
  int         errors = 0;
  int         checks = 0;
  int         beat_cnt[4];
  logic [7:0] tag[4];
  int         fin_cnt = 0;
  int         got_beats = 0;
  bit         in_burst = 0;
  int         owner = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int i, input logic [7:0] t, input int k);
    return {8'hA0 + 8'(i), 8'h5C, t, 8'(k)};
  endfunction

  function automatic vec_t mkv(input logic [3:0] g, input logic [3:0] l, input logic [15:0] r,
                               input logic e, input int c, input int d, input int ch);
    vec_t v;
    v.grant = g; v.len = l; v.rdy = r; v.exp_err = e; v.exp_cyc = c; v.drop_at = d; v.chg_at = ch;
    return v;
  endfunction

  task automatic refresh();
    for (int i = 0; i < 4; i++) m_data[i] = mk(i, tag[i], beat_cnt[i]);
  endtask

  task automatic push_burst(input int o, input int len);
    beat_t e;
    for (int k = 0; k <= len; k++) begin
      e.data = mk(o, tag[o], k);
      e.id   = 2'(o);
      e.last = (k == len);
      sb.push_back(e);
    end
  endtask

  // One clock: monitor at negedge, then advance master data after the edge.
  task automatic step();
    logic [3:0] acc;
    logic [3:0] exp_mr;
    beat_t      e;
    @(negedge clk);
    exp_mr = (in_burst && s_ready) ? 4'(4'b0001 << owner) : 4'b0000;
    chk("m_ready", 64'(m_ready), 64'(exp_mr));
    chk("s_valid", 64'(s_valid), in_burst ? 64'(m_valid[owner]) : 64'd0);
    if (s_valid && s_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %0h with nothing expected (t=%0t)", s_data, $time);
      end else begin
        e = sb.pop_front();
        chk("s_data", 64'(s_data), 64'(e.data));
        chk("s_id", 64'(s_id), 64'(e.id));
        chk("s_last", 64'(s_last), 64'(e.last));
        got_beats++;
        if (e.last) in_burst = 0;
      end
    end else if (s_valid && sb.size() > 0) begin
      chk("stall_data", 64'(s_data), 64'(sb[0].data));
    end
    if (session_is_finished) fin_cnt++;
    acc = m_valid & m_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) beat_cnt[i]++;
    refresh();
  endtask

  task automatic run_session(input vec_t v);
    int o, cyc, f0;
    bit oh;
    oh = ($countones(v.grant) == 1);
    o = 0;
    for (int i = 0; i < 4; i++) if (v.grant[i]) o = i;
    for (int i = 0; i < 4; i++) begin
      m_len[i]    = (i == o) ? v.len : ~v.len;
      tag[i]      = tag[i] + 8'd1;
      beat_cnt[i] = 0;
    end
    refresh();
    m_valid   = 4'hF;
    got_beats = 0;
    f0        = fin_cnt;
    if (oh) push_burst(o, int'(v.len));
    owner   = o;
    grant   = v.grant;
    s_ready = v.rdy[0];
    step();
    if (oh) begin
      in_burst = 1;
      cyc = 1;
      while (fin_cnt == f0 && cyc < 200) begin
        s_ready = v.rdy[cyc % 16];
        if (cyc == v.drop_at) grant = '0;
        if (cyc == v.chg_at) m_len = '0;
        step();
        cyc++;
      end
      chk("fin_pulse", 64'(fin_cnt - f0), 64'd1);
      chk("beats", 64'(got_beats), 64'(int'(v.len) + 1));
      if (v.exp_cyc != 0) chk("latency", 64'(cyc), 64'(v.exp_cyc));
      chk("busy_settle", 64'(busy), 64'd1);
      chk("fin_settle", 64'(session_is_finished), 64'd0);
      step();
      chk("busy_idle", 64'(busy), 64'd0);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      chk("fin_once", 64'(fin_cnt - f0), 64'd1);
    end else begin
      repeat (3) begin
        step();
        chk("busy_err_idle", 64'(busy), 64'd0);
      end
      chk("no_beats", 64'(got_beats), 64'd0);
    end
    grant    = '0;
    in_burst = 0;
    chk("protocol_err", 64'(protocol_err), 64'(v.exp_err));
    sb.delete();
    step();
  endtask

  initial begin
    int f0;
    tbl[0]  = mkv(4'b0100, 4'd3,  16'hFFFF, 1'b0, 6,  0, 0);  // single burst
    tbl[1]  = mkv(4'b0001, 4'd1,  16'hFFF3, 1'b0, 6,  0, 0);  // ready 1,0,0,1
    tbl[2]  = mkv(4'b0010, 4'd0,  16'hFFFF, 1'b0, 3,  0, 0);  // 1-beat minimum
    tbl[3]  = mkv(4'b0001, 4'd2,  16'hAAAA, 1'b0, 7,  0, 0);
    tbl[4]  = mkv(4'b0010, 4'd5,  16'h5A5F, 1'b0, 0,  0, 0);
    tbl[5]  = mkv(4'b1000, 4'd15, 16'hFFFF, 1'b0, 18, 0, 0);  // max length
    tbl[6]  = mkv(4'b1000, 4'd15, 16'h7FFD, 1'b0, 0,  0, 0);
    tbl[7]  = mkv(4'b0100, 4'd3,  16'hFFFF, 1'b0, 6,  0, 2);  // m_len changes mid-burst
    tbl[8]  = mkv(4'b0001, 4'd5,  16'hFFFF, 1'b1, 8,  3, 0);  // grant dropped mid-burst
    tbl[9]  = mkv(4'b0011, 4'd2,  16'hFFFF, 1'b1, 0,  0, 0);  // multi-hot in IDLE
    tbl[10] = mkv(4'b0100, 4'd7,  16'hFFFF, 1'b1, 10, 0, 0);  // error stays sticky
    tbl[11] = mkv(4'b1100, 4'd1,  16'hFFFF, 1'b1, 0,  0, 0);

    for (int i = 0; i < 4; i++) begin
      tag[i] = 8'(i * 16);
      beat_cnt[i] = 0;
    end
    rst_a = 1'b1; grant = '0; m_valid = '0; s_ready = 1'b0; m_len = '0;
    refresh();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fin", 64'(session_is_finished), 64'd0);
    chk("rst_s_valid", 64'(s_valid), 64'd0);
    chk("rst_s_last", 64'(s_last), 64'd0);
    chk("rst_m_ready", 64'(m_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(protocol_err), 64'd0);
    chk("rst_s_id", 64'(s_id), 64'd0);
    rst_a = 1'b0;
    step();

    for (int t = 0; t < 12; t++) run_session(tbl[t]);

    // Reset lands after beat 2 of an 8-beat burst.
    owner = 2;
    tag[2] = tag[2] + 8'd1;
    for (int i = 0; i < 4; i++) beat_cnt[i] = 0;
    refresh();
    m_len = '0; m_len[2] = 4'd7; m_valid = 4'hF; s_ready = 1'b1;
    push_burst(2, 7);
    got_beats = 0; f0 = fin_cnt;
    grant = 4'b0100;
    step();
    in_burst = 1;
    step();
    step();
    chk("pre_rst_beats", 64'(got_beats), 64'd2);
    rst_a = 1'b1;
    #1;
    chk("midrst_s_valid", 64'(s_valid), 64'd0);
    chk("midrst_s_last", 64'(s_last), 64'd0);
    chk("midrst_m_ready", 64'(m_ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_fin", 64'(session_is_finished), 64'd0);
    chk("midrst_err", 64'(protocol_err), 64'd0);
    in_burst = 0;
    sb.delete();
    grant = '0;
    step();
    step();
    chk("midrst_no_pulse", 64'(fin_cnt - f0), 64'd0);
    rst_a = 1'b0;
    run_session(mkv(4'b0001, 4'd2, 16'hFFFF, 1'b0, 5, 0, 0));
    run_session(mkv(4'b0010, 4'd4, 16'hFFFF, 1'b0, 7, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
